// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with a NOP-bubble sequencer for decode hazards.
// Optional STALL_PERF_CNT_EN adds stall-cycle and bubble counters.
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic [1:0]        count_i,
  input  logic              flush_i,
  input  logic              exe_busy_i,
  input  logic              id_w_rf_i,
  input  logic              id_w_hi_i,
  input  logic              id_w_lo_i,
  input  logic              id_w_cp0_i,
  input  logic              id_w_dm_i,
  input  logic              id_dm_cs_i,
  input  logic              id_mfc0_i,
  input  logic              id_mtc0_i,
  input  logic              id_eret_i,
  input  logic              id_exc_i,
  input  logic [4:0]        id_cause_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [DATA_W-1:0] id_rs_i,
  input  logic [DATA_W-1:0] id_rt_i,
  input  logic [DATA_W-1:0] id_imm_i,
  output logic              hold_o,
  output logic              e_valid_o,
  output logic              e_w_rf_o,
  output logic              e_w_hi_o,
  output logic              e_w_lo_o,
  output logic              e_w_cp0_o,
  output logic              e_w_dm_o,
  output logic              e_dm_cs_o,
  output logic              e_mfc0_o,
  output logic              e_mtc0_o,
  output logic              e_eret_o,
  output logic              e_exc_o,
  output logic [4:0]        e_cause_o,
  output logic [4:0]        e_rd_addr_o,
  output logic [CTRL_W-1:0] e_ctrl_o,
  output logic [DATA_W-1:0] e_pc_o,
  output logic [DATA_W-1:0] e_rs_o,
  output logic [DATA_W-1:0] e_rt_o,
  output logic [DATA_W-1:0] e_imm_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  localparam int BW = 20 + CTRL_W + 4 * DATA_W;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUBBLE = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic [BW-1:0]   r_e, w_e_nxt, w_id;
  logic            r_valid, w_valid_nxt;
  logic            w_hold, w_stall_bubble;
  logic            w_unused;

  assign w_id = {id_w_rf_i, id_w_hi_i, id_w_lo_i, id_w_cp0_i, id_w_dm_i, id_dm_cs_i,
                 id_mfc0_i, id_mtc0_i, id_eret_i, id_exc_i, id_cause_i, id_rd_addr_i,
                 id_ctrl_i, id_pc_i, id_rs_i, id_rt_i, id_imm_i};

  // Feedback outputs come only from r_e, never from id_* inputs.
  assign {e_w_rf_o, e_w_hi_o, e_w_lo_o, e_w_cp0_o, e_w_dm_o, e_dm_cs_o,
          e_mfc0_o, e_mtc0_o, e_eret_o, e_exc_o, e_cause_o, e_rd_addr_o,
          e_ctrl_o, e_pc_o, e_rs_o, e_rt_o, e_imm_o} = r_e;
  assign e_valid_o = r_valid;
  assign hold_o    = w_hold;
  assign w_unused  = count_i[1];

  // Next-state, next EXE contents and hold: flush > busy > bubble/stall > load.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_e_nxt        = r_e;
    w_valid_nxt    = r_valid;
    w_hold         = 1'b0;
    w_stall_bubble = 1'b0;
    if (flush_i) begin
      w_e_nxt     = {BW{1'b0}};
      w_valid_nxt = 1'b0;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 2'd0;
    end else if (exe_busy_i) begin
      w_hold = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (stall_i) begin
            w_hold         = 1'b1;
            w_stall_bubble = 1'b1;
            w_e_nxt        = {BW{1'b0}};
            w_valid_nxt    = 1'b0;
            if (count_i[0]) begin
              w_cnt_nxt   = 2'd1;
              w_state_nxt = ST_BUBBLE;
            end else begin
              w_cnt_nxt   = 2'd0;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_e_nxt     = w_id;
            w_valid_nxt = 1'b1;
          end
        end
        ST_BUBBLE: begin
          w_hold         = 1'b1;
          w_stall_bubble = 1'b1;
          w_e_nxt        = {BW{1'b0}};
          w_valid_nxt    = 1'b0;
          // A zero count here is unreachable; treat it as the last bubble.
          if (r_cnt <= 2'd1) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt - 2'd1;
            w_state_nxt = ST_BUBBLE;
          end
        end
        default: begin
          w_e_nxt     = {BW{1'b0}};
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = 2'd0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Pipeline register, sequencer state and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_e     <= {BW{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_e     <= w_e_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_bubble_cnt;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_bubble_cnt   <= 32'd0;
    end else begin
      r_stall_cycles <= r_stall_cycles + {31'd0, w_hold};
      r_bubble_cnt   <= r_bubble_cnt + {31'd0, w_stall_bubble};
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign bubble_cnt_o   = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomized self-checking bench for id_exe_stage_reg against a pending-bubble model.
// Perf-counter checks are compiled in when STALL_PERF_CNT_EN is defined.
module tb_id_exe_stage_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 24;
  localparam int BW = 20 + CTRL_W + 4 * DATA_W;

  logic clk = 1'b0, rst_n = 1'b0;
  logic stall_i = 1'b0, flush_i = 1'b0, exe_busy_i = 1'b0;
  logic [1:0] count_i = 2'd0;
  logic id_w_rf_i, id_w_hi_i, id_w_lo_i, id_w_cp0_i, id_w_dm_i, id_dm_cs_i;
  logic id_mfc0_i, id_mtc0_i, id_eret_i, id_exc_i;
  logic [4:0] id_cause_i, id_rd_addr_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [DATA_W-1:0] id_pc_i, id_rs_i, id_rt_i, id_imm_i;
  logic hold_o, e_valid_o;
  logic e_w_rf_o, e_w_hi_o, e_w_lo_o, e_w_cp0_o, e_w_dm_o, e_dm_cs_o;
  logic e_mfc0_o, e_mtc0_o, e_eret_o, e_exc_o;
  logic [4:0] e_cause_o, e_rd_addr_o;
  logic [CTRL_W-1:0] e_ctrl_o;
  logic [DATA_W-1:0] e_pc_o, e_rs_o, e_rt_o, e_imm_o;
  logic [31:0] stall_cycles_o, bubble_cnt_o;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .count_i(count_i), .flush_i(flush_i),
    .exe_busy_i(exe_busy_i), .id_w_rf_i(id_w_rf_i), .id_w_hi_i(id_w_hi_i),
    .id_w_lo_i(id_w_lo_i), .id_w_cp0_i(id_w_cp0_i), .id_w_dm_i(id_w_dm_i),
    .id_dm_cs_i(id_dm_cs_i), .id_mfc0_i(id_mfc0_i), .id_mtc0_i(id_mtc0_i),
    .id_eret_i(id_eret_i), .id_exc_i(id_exc_i), .id_cause_i(id_cause_i),
    .id_rd_addr_i(id_rd_addr_i), .id_ctrl_i(id_ctrl_i), .id_pc_i(id_pc_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_imm_i(id_imm_i), .hold_o(hold_o),
    .e_valid_o(e_valid_o), .e_w_rf_o(e_w_rf_o), .e_w_hi_o(e_w_hi_o), .e_w_lo_o(e_w_lo_o),
    .e_w_cp0_o(e_w_cp0_o), .e_w_dm_o(e_w_dm_o), .e_dm_cs_o(e_dm_cs_o),
    .e_mfc0_o(e_mfc0_o), .e_mtc0_o(e_mtc0_o), .e_eret_o(e_eret_o), .e_exc_o(e_exc_o),
    .e_cause_o(e_cause_o), .e_rd_addr_o(e_rd_addr_o), .e_ctrl_o(e_ctrl_o),
    .e_pc_o(e_pc_o), .e_rs_o(e_rs_o), .e_rt_o(e_rt_o), .e_imm_o(e_imm_o)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles_o(stall_cycles_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

`ifndef STALL_PERF_CNT_EN
  assign stall_cycles_o = 32'd0;
  assign bubble_cnt_o   = 32'd0;
`endif

  wire [BW-1:0] id_cat = {id_w_rf_i, id_w_hi_i, id_w_lo_i, id_w_cp0_i, id_w_dm_i, id_dm_cs_i,
                          id_mfc0_i, id_mtc0_i, id_eret_i, id_exc_i, id_cause_i, id_rd_addr_i,
                          id_ctrl_i, id_pc_i, id_rs_i, id_rt_i, id_imm_i};
  wire [BW-1:0] e_cat = {e_w_rf_o, e_w_hi_o, e_w_lo_o, e_w_cp0_o, e_w_dm_o, e_dm_cs_o,
                         e_mfc0_o, e_mtc0_o, e_eret_o, e_exc_o, e_cause_o, e_rd_addr_o,
                         e_ctrl_o, e_pc_o, e_rs_o, e_rt_o, e_imm_o};

  int checks = 0;
  int errors = 0;

  // Reference model: EXE contents plus the number of forced bubbles still owed.
  logic [BW-1:0] m_e;
  logic m_valid;
  int m_pend;
  logic [31:0] m_stall, m_bub;

  function automatic logic model_hold();
    if (flush_i) return 1'b0;
    else if (exe_busy_i) return 1'b1;
    else return (m_pend > 0) || stall_i;
  endfunction

  task automatic model_reset();
    m_e = '0; m_valid = 1'b0; m_pend = 0; m_stall = 32'd0; m_bub = 32'd0;
  endtask

  task automatic rand_id();
    {id_w_rf_i, id_w_hi_i, id_w_lo_i, id_w_cp0_i, id_w_dm_i} = 5'($urandom);
    {id_dm_cs_i, id_mfc0_i, id_mtc0_i, id_eret_i, id_exc_i} = 5'($urandom);
    id_cause_i = 5'($urandom); id_rd_addr_i = 5'($urandom); id_ctrl_i = 24'($urandom);
    id_pc_i = $urandom; id_rs_i = $urandom; id_rt_i = $urandom; id_imm_i = $urandom;
  endtask

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    logic h;
    h = model_hold();
    @(posedge clk);
    if (flush_i) begin
      m_e = '0; m_valid = 1'b0; m_pend = 0;
    end else if (exe_busy_i) begin
      m_pend = m_pend;
    end else if (m_pend > 0) begin
      m_e = '0; m_valid = 1'b0; m_pend = m_pend - 1; m_bub = m_bub + 32'd1;
    end else if (stall_i) begin
      m_e = '0; m_valid = 1'b0; m_pend = count_i[0] ? 1 : 0; m_bub = m_bub + 32'd1;
    end else begin
      m_e = id_cat; m_valid = 1'b1;
    end
    if (h) m_stall = m_stall + 32'd1;
    #1;
  endtask

  task automatic test_reset();
    rand_id(); stall_i = 1'b0; rst_n = 1'b0; model_reset();
    #12;
    checks++; if (e_cat !== '0 || e_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got %h/%b want 0/0", e_cat, e_valid_o); end
    checks++; if (hold_o !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %b want 0", hold_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    rand_id(); stall_i = 1'b0; id_rd_addr_i = 5'd8; id_w_rf_i = 1'b1; id_rs_i = 32'h1234;
    #1;
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL normal_hold: got %b want 0", hold_o); end
    tick();
    checks++; if (e_rd_addr_o !== 5'd8 || e_w_rf_o !== 1'b1 || e_rs_o !== 32'h1234 || e_valid_o !== 1'b1) begin
      errors++; $display("FAIL normal_load: got rd=%0d wrf=%b rs=%h v=%b want 8 1 1234 1",
                         e_rd_addr_o, e_w_rf_o, e_rs_o, e_valid_o); end
    checks++; if (e_cat !== id_cat) begin errors++; $display("FAIL normal_all: got %h want %h", e_cat, id_cat); end
  endtask

  task automatic test_exe_hazard();
    logic [1:0] exp_hold [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp_val  [3] = '{1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      rand_id(); stall_i = (c == 0); count_i = (c == 0) ? 2'b11 : 2'b00;
      #1;
      checks++; if (hold_o !== exp_hold[c][0]) begin
        errors++; $display("FAIL exe_hazard_hold[%0d]: got %b want %b", c, hold_o, exp_hold[c][0]); end
      tick();
      checks++; if (e_valid_o !== exp_val[c][0] || e_cat !== m_e) begin
        errors++; $display("FAIL exe_hazard_exe[%0d]: got v=%b %h want v=%b %h", c, e_valid_o, e_cat, exp_val[c][0], m_e); end
    end
  endtask

  task automatic test_mem_hazard();
    for (int c = 0; c < 2; c++) begin
      rand_id(); stall_i = (c == 0); count_i = (c == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if (hold_o !== (c == 0)) begin
        errors++; $display("FAIL mem_hazard_hold[%0d]: got %b want %b", c, hold_o, (c == 0)); end
      tick();
      checks++; if (e_valid_o !== (c == 1) || e_cat !== m_e) begin
        errors++; $display("FAIL mem_hazard_exe[%0d]: got v=%b want v=%b", c, e_valid_o, (c == 1)); end
    end
  endtask

  task automatic test_flush_bubble();
    rand_id(); stall_i = 1'b1; count_i = 2'b11; #1; tick();
    rand_id(); stall_i = 1'b0; flush_i = 1'b1; #1;
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL flush_hold: got %b want 0", hold_o); end
    tick();
    checks++; if (e_valid_o !== 1'b0 || e_cat !== '0) begin
      errors++; $display("FAIL flush_bubble: got v=%b %h want 0 0", e_valid_o, e_cat); end
    flush_i = 1'b0; rand_id(); #1;
    checks++; if (hold_o !== 1'b0) begin errors++; $display("FAIL flush_idle_hold: got %b want 0", hold_o); end
    tick();
    checks++; if (e_valid_o !== 1'b1 || e_cat !== id_cat) begin
      errors++; $display("FAIL flush_next_load: got v=%b %h want 1 %h", e_valid_o, e_cat, id_cat); end
  endtask

  task automatic test_busy();
    logic [BW-1:0] held;
    logic [31:0] sc0;
    rand_id(); stall_i = 1'b0; #1; tick();
    held = e_cat; sc0 = stall_cycles_o;
    for (int c = 0; c < 3; c++) begin
      rand_id(); exe_busy_i = 1'b1; stall_i = 1'($urandom); count_i = 2'($urandom); #1;
      checks++; if (hold_o !== 1'b1) begin errors++; $display("FAIL busy_hold[%0d]: got %b want 1", c, hold_o); end
      tick();
      checks++; if (e_cat !== held || e_valid_o !== 1'b1) begin
        errors++; $display("FAIL busy_keep[%0d]: got %h want %h", c, e_cat, held); end
    end
    exe_busy_i = 1'b0; stall_i = 1'b0;
`ifdef STALL_PERF_CNT_EN
    checks++; if (stall_cycles_o !== sc0 + 32'd3) begin
      errors++; $display("FAIL busy_perf: got %0d want %0d", stall_cycles_o, sc0 + 32'd3); end
`endif
  endtask

  task automatic test_reset_mid_sequence();
    rand_id(); stall_i = 1'b1; count_i = 2'b01; #1; tick();
    stall_i = 1'b0; #2; rst_n = 1'b0; model_reset(); #1;
    checks++; if (e_cat !== '0 || e_valid_o !== 1'b0 || hold_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got %h v=%b h=%b want 0 0 0", e_cat, e_valid_o, hold_o); end
    #1; rst_n = 1'b1; rand_id(); #1;
    tick();
    checks++; if (e_valid_o !== 1'b1 || e_cat !== id_cat) begin
      errors++; $display("FAIL reset_drop_pending: got v=%b want 1", e_valid_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_id();
      stall_i = ($urandom_range(0, 99) < 35); count_i = 2'($urandom);
      flush_i = ($urandom_range(0, 99) < 8); exe_busy_i = ($urandom_range(0, 99) < 15);
      #1;
      checks++; if (hold_o !== model_hold()) begin
        errors++; $display("FAIL rand_hold[%0d]: got %b want %b", c, hold_o, model_hold()); end
      tick();
      checks++; if (e_cat !== m_e || e_valid_o !== m_valid) begin
        errors++; $display("FAIL rand_exe[%0d]: got v=%b %h want v=%b %h", c, e_valid_o, e_cat, m_valid, m_e); end
`ifdef STALL_PERF_CNT_EN
      checks++; if (stall_cycles_o !== m_stall || bubble_cnt_o !== m_bub) begin
        errors++; $display("FAIL rand_perf[%0d]: got %0d/%0d want %0d/%0d", c, stall_cycles_o, bubble_cnt_o, m_stall, m_bub); end
`endif
    end
    flush_i = 1'b0; exe_busy_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_exe_hazard();
    test_mem_hazard();
    test_flush_bubble();
    test_busy();
    test_reset_mid_sequence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
